// File: rtl/dram_amm_responder.sv
// -----------------------------------------------------------------------------
// dram_amm_responder
//
// On-chip stand-in for the DDR4 EMIF behind the DRAM FIFO front-end. It answers
// the single-port AMM request side from a block RAM. Writes are single beat.
// Reads are fixed-length bursts whose beats come back with a valid strobe and
// the info tag that was captured with the request. Calibration is emulated by
// a fixed countdown after reset.
//
// Ports
//   clk          in   1        single clock
//   resetn       in   1        synchronous, active-low reset
//   rdreq        in   1        read burst request (taken when rdreq & ready)
//   wrreq        in   1        write request (taken when wrreq & ready)
//   address      in   ADDR_W   beat address: burst base or write target
//   d            in   DATA_W   write data
//   d_info       in   INFO_W   tag captured with an accepted rdreq
//   ready        out  1        a request can be accepted this cycle
//   q            out  DATA_W   read data beat (don't-care while q_valid=0)
//   q_valid      out  1        q / q_info valid this cycle
//   q_info       out  INFO_W   tag of the burst that q belongs to
//   cal_success  out  1        calibration done, sticky until reset
//   err          out  1        sticky: rdreq and wrreq accepted together
// -----------------------------------------------------------------------------
module dram_amm_responder #(
    parameter int DATA_W      = 512,
    parameter int ADDR_W      = 10,
    parameter int BURST_COUNT = 4,
    parameter int RD_LATENCY  = 3,
    parameter int CAL_CYCLES  = 16,
    parameter int INFO_W      = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rdreq,
    input  logic              wrreq,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] d,
    input  logic [INFO_W-1:0] d_info,
    output logic              ready,
    output logic [DATA_W-1:0] q,
    output logic              q_valid,
    output logic [INFO_W-1:0] q_info,
    output logic              cal_success,
    output logic              err
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int CAL_W  = (CAL_CYCLES > 1) ? $clog2(CAL_CYCLES) : 1;
    localparam int BEAT_W = (BURST_COUNT > 1) ? $clog2(BURST_COUNT) : 1;

    localparam logic [1:0] ST_CAL      = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_RD_BURST = 2'd2;

    // -------------------------------------------------------------------------
    // Control state
    // -------------------------------------------------------------------------
    logic [1:0]        state_q,       state_d;
    logic [CAL_W-1:0]  cal_cnt_q,     cal_cnt_d;
    logic              cal_success_q, cal_success_d;
    logic              err_q,         err_d;
    logic [ADDR_W-1:0] base_q,        base_d;
    logic [INFO_W-1:0] info_q,        info_d;
    logic [BEAT_W-1:0] beat_q,        beat_d;

    // Per-cycle decisions
    logic              accept_wr;
    logic              issue_vld;
    logic [ADDR_W-1:0] issue_addr;
    logic [INFO_W-1:0] issue_info;

    // Storage and read pipeline. Stage 0 is the registered RAM read; the
    // remaining RD_LATENCY-1 stages only delay. Valid and info move in
    // lockstep with data so each beat keeps its own tag.
    logic [DATA_W-1:0] mem_q       [DEPTH];
    logic [DATA_W-1:0] data_pipe_q [RD_LATENCY];
    logic              vld_pipe_q  [RD_LATENCY];
    logic [INFO_W-1:0] info_pipe_q [RD_LATENCY];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a signal unassigned and infer
        // a latch.
        state_d       = state_q;
        cal_cnt_d     = cal_cnt_q;
        cal_success_d = cal_success_q;
        err_d         = err_q;
        base_d        = base_q;
        info_d        = info_q;
        beat_d        = beat_q;
        accept_wr     = 1'b0;
        issue_vld     = 1'b0;
        issue_addr    = address;
        issue_info    = d_info;

        case (state_q)
            ST_CAL: begin
                if (cal_cnt_q == CAL_W'(CAL_CYCLES - 1)) begin
                    state_d       = ST_IDLE;
                    cal_success_d = 1'b1;
                end else begin
                    cal_cnt_d = cal_cnt_q + CAL_W'(1);
                end
            end

            ST_IDLE: begin
                if (wrreq) begin
                    // A write always wins; a read arriving with it is dropped
                    // and flagged, and the responder stays ready.
                    accept_wr = 1'b1;
                    if (rdreq) begin
                        err_d = 1'b1;
                    end
                end else if (rdreq) begin
                    // Beat 0 goes out in the accept cycle itself so the burst
                    // has no leading bubble.
                    issue_vld = 1'b1;
                    base_d    = address;
                    info_d    = d_info;
                    beat_d    = BEAT_W'(1);
                    state_d   = (BURST_COUNT > 1) ? ST_RD_BURST : ST_IDLE;
                end
            end

            ST_RD_BURST: begin
                issue_vld  = 1'b1;
                // ADDR_W-bit sum: wraps from DEPTH-1 back to 0.
                issue_addr = base_q + ADDR_W'(beat_q);
                issue_info = info_q;
                beat_d     = beat_q + BEAT_W'(1);
                if (beat_q == BEAT_W'(BURST_COUNT - 1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_CAL;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers and valid/info pipeline
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its pre-edge value, independent of statement order.
        if (!resetn) begin
            state_q       <= ST_CAL;
            cal_cnt_q     <= '0;
            cal_success_q <= 1'b0;
            err_q         <= 1'b0;
            base_q        <= '0;
            info_q        <= '0;
            beat_q        <= '0;
            // Discards every in-flight beat of an interrupted burst.
            for (int k = 0; k < RD_LATENCY; k++) begin
                vld_pipe_q[k]  <= 1'b0;
                info_pipe_q[k] <= '0;
            end
        end else begin
            state_q        <= state_d;
            cal_cnt_q      <= cal_cnt_d;
            cal_success_q  <= cal_success_d;
            err_q          <= err_d;
            base_q         <= base_d;
            info_q         <= info_d;
            beat_q         <= beat_d;
            vld_pipe_q[0]  <= issue_vld;
            info_pipe_q[0] <= issue_vld ? issue_info : '0;
            for (int k = 1; k < RD_LATENCY; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                info_pipe_q[k] <= info_pipe_q[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM and data pipeline
    // -------------------------------------------------------------------------
    // NOTE: the RAM and its data path carry no reset; contents survive reset
    // and this lets the array map onto block RAM. Only valid needs clearing.
    always_ff @(posedge clk) begin
        if (accept_wr && resetn) begin
            mem_q[address] <= d;
        end
        // A write lands at the end of its cycle, so a beat issued in any later
        // cycle reads the new data. ready keeps reads and writes from sharing
        // a cycle, so no bypass path is needed.
        data_pipe_q[0] <= mem_q[issue_addr];
        for (int k = 1; k < RD_LATENCY; k++) begin
            data_pipe_q[k] <= data_pipe_q[k-1];
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign ready       = (state_q == ST_IDLE);
    assign q           = data_pipe_q[RD_LATENCY-1];
    assign q_valid     = vld_pipe_q[RD_LATENCY-1];
    assign q_info      = info_pipe_q[RD_LATENCY-1];
    assign cal_success = cal_success_q;
    assign err         = err_q;

endmodule
